// File: rtl/ov5640_init_ctrl.sv
// ov5640_init_ctrl: OV5640 power-on sequencer that streams a ROM register table to the SCCB master.
// Define OV5640_INIT_DELAY_EN to treat entries with reg_addr 16'hFFFF as reg_val-millisecond delays.
module ov5640_init_ctrl #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int REG_NUM = 252,
   parameter int MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        cam_pwdn,
   output logic        cam_rst_n,
   output logic [7:0]  rom_addr,
   input  logic [23:0] rom_data,
   output logic        sccb_valid,
   input  logic        sccb_ready,
   output logic [15:0] sccb_addr,
   output logic [7:0]  sccb_data,
   input  logic        sccb_done,
   input  logic        sccb_nack,
   output logic        init_done,
   output logic        init_err
);
   localparam logic [31:0] MS_CNT = 32'(CLK_FREQ_HZ / 1000);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [3:0] S_PWDN = 4'd0, S_RST = 4'd1, S_BOOT = 4'd2, S_FETCH = 4'd3, S_LOAD = 4'd4,
                          S_REQ = 4'd5, S_WAIT = 4'd6, S_DONE = 4'd7, S_ERR = 4'd8;
   logic [3:0] state, nxt;
   logic [31:0] cnt;
   logic [RW-1:0] retry;
   logic last;
   assign last = rom_addr == 8'(REG_NUM - 1);
`ifdef OV5640_INIT_DELAY_EN
   localparam logic [3:0] S_DLY = 4'd9;
   logic dly_end;
   // rom_addr was advanced on entry to S_DLY, so the next entry is already fetched when the delay ends
   assign dly_end = sccb_data == 8'd0 || cnt == MS_CNT * {24'd0, sccb_data} - 32'd1;
`endif
   always_comb begin
      nxt = state;
      case (state)
         S_PWDN:  nxt = cnt == MS_CNT - 32'd1 ? S_RST : S_PWDN;
         S_RST:   nxt = cnt == MS_CNT - 32'd1 ? S_BOOT : S_RST;
         S_BOOT:  nxt = cnt == 32'd20 * MS_CNT - 32'd1 ? S_FETCH : S_BOOT;
         S_FETCH: nxt = S_LOAD;
`ifdef OV5640_INIT_DELAY_EN
         S_LOAD:  nxt = rom_data[23:8] == 16'hFFFF ? S_DLY : S_REQ;
         S_DLY:   nxt = !dly_end ? S_DLY : rom_addr == 8'(REG_NUM) ? S_DONE : S_LOAD;
`else
         S_LOAD:  nxt = S_REQ;
`endif
         S_REQ:   nxt = sccb_ready ? S_WAIT : S_REQ;
         S_WAIT:  nxt = !sccb_done ? S_WAIT : !sccb_nack ? (last ? S_DONE : S_FETCH) :
                        retry < RW'(MAX_RETRY) ? S_REQ : S_ERR;
         default: nxt = state;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_PWDN;
         cnt <= '0;
         retry <= '0;
         cam_pwdn <= 1'b1;
         cam_rst_n <= 1'b0;
         rom_addr <= '0;
         sccb_valid <= 1'b0;
         sccb_addr <= '0;
         sccb_data <= '0;
         init_done <= 1'b0;
         init_err <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= nxt != state ? '0 : cnt + 32'd1;
         cam_pwdn <= nxt == S_PWDN;
         cam_rst_n <= nxt != S_PWDN && nxt != S_RST;
         sccb_valid <= nxt == S_REQ;
         init_done <= nxt == S_DONE;
         init_err <= nxt == S_ERR;
         if (state == S_LOAD) {sccb_addr, sccb_data} <= rom_data;
         if (state == S_WAIT && sccb_done && !sccb_nack) begin
            retry <= '0;
            rom_addr <= rom_addr + 8'd1;
         end
         if (state == S_WAIT && sccb_done && sccb_nack && retry < RW'(MAX_RETRY)) retry <= retry + 1'b1;
`ifdef OV5640_INIT_DELAY_EN
         if (state == S_LOAD && nxt == S_DLY) rom_addr <= rom_addr + 8'd1;
`endif
      end
   end
endmodule

// File: tb/tb_ov5640_init_ctrl.sv
// tb_ov5640_init_ctrl: randomized episodes checked every cycle against a timeline model of the sequencer.
// The model predicts when each request, done and error must appear from the power-up and per-entry timing rules.
`timescale 1ns/1ps
module tb_ov5640_init_ctrl;
   localparam int N = 3, MS = 10, MAXR = 3, INF = 1 << 30;
   localparam int M_BASIC = 0, M_HOLD = 1, M_N1 = 2, M_N0 = 3, M_RST = 4, M_DLY = 5, M_RND = 6;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cam_pwdn, cam_rst_n, sccb_valid, init_done, init_err;
   logic [7:0] rom_addr, sccb_data;
   logic [15:0] sccb_addr;
   logic [23:0] rom_data;
   logic sccb_ready = 1'b0, sccb_done = 1'b0, sccb_nack = 1'b0;
   logic [23:0] rom [256];
   ov5640_init_ctrl #(.CLK_FREQ_HZ(10_000), .REG_NUM(N), .MAX_RETRY(MAXR)) dut (
      .clk(clk), .rst_n(rst_n), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
      .rom_addr(rom_addr), .rom_data(rom_data), .sccb_valid(sccb_valid), .sccb_ready(sccb_ready),
      .sccb_addr(sccb_addr), .sccb_data(sccb_data), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
      .init_done(init_done), .init_err(init_err));
   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];
   int n_chk = 0, n_pass = 0;
   // t counts active clock edges since reset release; outputs observed at t reflect edge t-1
   int t, m_idx, m_retry, m_valid_at, done_at, err_at, done_t, last_hs, hold_left, n_acc;
   bit m_pend, busy, dn_nack;
   int mode, lat_cfg, hold_cfg;
   bit rdy_rand, spur;
   int fst_pwdn0, fst_rst1, fst_done, fst_err;
   int v_t[N], h_t[N], ack_t[N], req_cnt[N];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (mode %0d, t=%0d): got %0h, expected %0h", name, mode, t, act, exp);
   endtask
   task automatic model_reset();
      t = 0; m_idx = 0; m_retry = 0; m_pend = 0; busy = 0; dn_nack = 0;
      done_t = -1; done_at = INF; err_at = INF; last_hs = -INF; hold_left = hold_cfg; n_acc = 0;
      fst_pwdn0 = -1; fst_rst1 = -1; fst_done = -1; fst_err = -1;
      for (int i = 0; i < N; i++) begin v_t[i] = -1; h_t[i] = -1; ack_t[i] = -1; req_cnt[i] = 0; end
   endtask
   // base: t a plain entry's request would appear; fin: t init_done appears if the table just ended
   task automatic advance(input int base, input int fin);
      int extra = 0;
      bit skip = 0;
`ifdef OV5640_INIT_DELAY_EN
      while (m_idx < N && rom[m_idx][23:8] == 16'hFFFF) begin
         extra += (rom[m_idx][7:0] == 8'd0 ? 1 : int'(rom[m_idx][7:0]) * MS) + 1;
         m_idx++;
         skip = 1;
      end
`endif
      if (m_idx == N) done_at = skip ? base - 1 + extra : fin;
      else begin m_pend = 1; m_valid_at = base + extra; end
   endtask
   function automatic bit pick_nack();
      case (mode)
         M_N1:    return m_idx == 1 && m_retry < 2;
         M_N0:    return m_idx == 0;
         M_RND:   return $urandom_range(3) == 0;
         default: return 0;
      endcase
   endfunction
   task automatic step(input bit do_rst);
      bit ev, rdy, hs;
      @(negedge clk);
      ev = m_pend && t >= m_valid_at;
      check("cam_pwdn", 32'(cam_pwdn), 32'(t < MS));
      check("cam_rst_n", 32'(cam_rst_n), 32'(t >= 2 * MS));
      check("sccb_valid", 32'(sccb_valid), 32'(ev));
      check("init_done", 32'(init_done), 32'(t >= done_at));
      check("init_err", 32'(init_err), 32'(t >= err_at));
      if (ev) begin
         check("sccb_addr", 32'(sccb_addr), 32'(rom[m_idx][23:8]));
         check("sccb_data", 32'(sccb_data), 32'(rom[m_idx][7:0]));
         check("rom_addr", 32'(rom_addr), 32'(m_idx));
      end
      if (!rst_n) begin
         check("rst_rom_addr", 32'(rom_addr), 32'd0);
         check("rst_sccb_addr", 32'(sccb_addr), 32'd0);
         check("rst_sccb_data", 32'(sccb_data), 32'd0);
      end
      if (!cam_pwdn && fst_pwdn0 < 0) fst_pwdn0 = t;
      if (cam_rst_n && fst_rst1 < 0) fst_rst1 = t;
      if (init_done && fst_done < 0) fst_done = t;
      if (init_err && fst_err < 0) fst_err = t;
      if (sccb_valid && m_idx < N && v_t[m_idx] < 0) v_t[m_idx] = t;
      if (do_rst) begin
         rst_n = 0; sccb_ready = 0; sccb_done = 0; sccb_nack = 0;
         model_reset();
         return;
      end
      if (!rst_n) begin
         rst_n = 1;
         advance(22 * MS + 2, 22 * MS + 1);
      end
      rdy = (hold_left > 0 && ev) ? 1'b0 : rdy_rand ? 1'($urandom_range(1)) : 1'b1;
      if (ev && !rdy && hold_left > 0) hold_left--;
      hs = ev && rdy;
      sccb_ready = rdy;
      if (busy && t == done_t) begin
         sccb_done = 1; sccb_nack = dn_nack; busy = 0;
         if (dn_nack) begin
            if (m_retry < MAXR) begin m_retry++; m_pend = 1; m_valid_at = t + 1; end
            else err_at = t + 1;
         end else begin
            ack_t[m_idx] = t; m_retry = 0; m_idx++;
            advance(t + 3, t + 1);
         end
      end else begin
         sccb_done = spur && !busy && $urandom_range(7) == 0;
         sccb_nack = 1'($urandom_range(1));
      end
      if (hs) begin
         m_pend = 0; busy = 1; n_acc++; req_cnt[m_idx]++; last_hs = t;
         if (h_t[m_idx] < 0) h_t[m_idx] = t;
         dn_nack = pick_nack();
         done_t = t + (lat_cfg > 0 ? lat_cfg : int'($urandom_range(6, 1)));
      end
      t++;
   endtask
   task automatic episode(input int md, input bit rr, input int lat, input int hold, input bit sp);
      bit fin = 0, did = 0, r;
      mode = md; rdy_rand = rr; lat_cfg = lat; hold_cfg = hold; spur = sp;
      step(1);
      for (int c = 0; c < 3000 && !fin; c++) begin
         r = md == M_RST && !did && busy && m_idx == 1 && t >= last_hs + 2;
         if (r) did = 1;
         step(r);
         fin = rst_n && (t > done_at + 8 || t > err_at + 30);
      end
      check("episode_end", 32'(fin), 32'd1);
   endtask
   initial begin
      mode = M_BASIC; hold_cfg = 0;
      model_reset();
      for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
      @(negedge clk);
      episode(M_BASIC, 0, 5, 0, 0);
      check("pwdn_fall_t", 32'(fst_pwdn0), 32'd10);
      check("rst_rise_t", 32'(fst_rst1), 32'd20);
      check("first_valid_t", 32'(v_t[0]), 32'd222);
      check("done_t", 32'(fst_done), 32'd244);
      check("writes", 32'(n_acc), 32'd3);
      episode(M_HOLD, 0, 5, 7, 0);
      check("hold_hs_t", 32'(h_t[0]), 32'd229);
      check("hold_writes", 32'(n_acc), 32'd3);
      episode(M_N1, 0, 5, 0, 0);
      check("n1_reqs", 32'(req_cnt[1]), 32'd3);
      check("n1_done_t", 32'(fst_done), 32'd256);
      check("n1_err", 32'(fst_err), 32'hFFFFFFFF);
      episode(M_N0, 0, 5, 0, 0);
      check("n0_err_t", 32'(fst_err), 32'd246);
      check("n0_reqs", 32'(n_acc), 32'd4);
      check("n0_done", 32'(fst_done), 32'hFFFFFFFF);
      episode(M_RST, 0, 5, 0, 0);
      check("rst_first_valid_t", 32'(v_t[0]), 32'd222);
      check("rst_done_t", 32'(fst_done), 32'd244);
      check("rst_writes", 32'(n_acc), 32'd3);
`ifdef OV5640_INIT_DELAY_EN
      rom[1] = 24'hFFFF02;
      episode(M_DLY, 0, 5, 0, 0);
      check("dly_gap", 32'(v_t[2] - ack_t[0]), 32'd24);
      check("dly_writes", 32'(n_acc), 32'd2);
`endif
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
         if (k == 1) rom[2] = 24'hFFFF05;
         if (k == 2) rom[0] = 24'hFFFF00;
         episode(M_RND, 1, 0, 0, 1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ov5640_init_ctrl.md
# ov5640_init_ctrl

Power-up and register-configuration sequencer for the OV5640 camera. It drives the camera PWDN and RESET pins through the datasheet power-on timing, then walks a register table held in an external synchronous ROM. Each entry is issued as a write request to the SCCB master over a valid/ready handshake, and NACKed writes are retried. It sits between the shell clock/reset and the SCCB master, and gates the capture path through `init_done`.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: clk frequency; `MS_CNT = CLK_FREQ_HZ/1000` cycles per millisecond.
- `REG_NUM`, 252: number of table entries, indices 0..REG_NUM-1.
- `MAX_RETRY`, 3: retries allowed per entry after a NACK.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `cam_pwdn`, out, 1: camera power-down, active-high.
- `cam_rst_n`, out, 1: camera reset, active-low.
- `rom_addr`, out, 8: table index.
- `rom_data`, in, 24: `{reg_addr[15:0], reg_val[7:0]}`, valid one cycle after `rom_addr` is presented.
- `sccb_valid`, out, 1: write request valid.
- `sccb_ready`, in, 1: SCCB master accepts the request.
- `sccb_addr`, out, 16: register address.
- `sccb_data`, out, 8: register value.
- `sccb_done`, in, 1: one-cycle pulse when a write completes.
- `sccb_nack`, in, 1: sampled with `sccb_done`; 1 means the write was not acknowledged.
- `init_done`, out, 1: table fully written; level signal.
- `init_err`, out, 1: retries exhausted; level signal.

## Operation
- States: S_PWDN → S_RST → S_BOOT → S_FETCH → S_LOAD → S_REQ → S_WAIT → (S_FETCH | S_DONE | S_ERR).
- S_PWDN: `cam_pwdn`=1, `cam_rst_n`=0 for 1 ms (MS_CNT cycles).
- S_RST: `cam_pwdn`=0, `cam_rst_n`=0 for 1 ms.
- S_BOOT: `cam_rst_n`=1; wait 20 ms (20*MS_CNT cycles) for sensor boot.
- S_FETCH: drive `rom_addr`=idx; wait one cycle for ROM latency.
- S_LOAD: register `rom_data` into `sccb_addr`/`sccb_data`.
- S_REQ: assert `sccb_valid`. Hold `sccb_valid`, `sccb_addr` and `sccb_data` stable until the cycle where `sccb_valid && sccb_ready`; then go to S_WAIT.
- S_WAIT on `sccb_done`:
  - `sccb_nack`=0: clear retry count, idx+1. If idx was REG_NUM-1, go to S_DONE; otherwise go to S_FETCH.
  - `sccb_nack`=1 and retry<MAX_RETRY: retry+1, return to S_REQ with the same addr/data.
  - `sccb_nack`=1 and retry=MAX_RETRY: go to S_ERR.
- S_DONE and S_ERR are terminal. Only `rst_n` leaves them.
- Counters: 32-bit delay counter, cleared on every state entry. A delay state ends when count = target-1. The retry counter is `$clog2(MAX_RETRY+1)` bits wide.
- `sccb_done` outside S_WAIT is ignored.

## Timing
- Reset values: state S_PWDN, `cam_pwdn`=1, `cam_rst_n`=0, `rom_addr`=0, `sccb_valid`=0, `sccb_addr`=0, `sccb_data`=0, `init_done`=0, `init_err`=0.
- All outputs are registered.
- First `sccb_valid` rises 22*MS_CNT+2 cycles after reset release.
- Per-entry overhead: 3 cycles from the `sccb_done` of one entry to `sccb_valid` for the next (FETCH, LOAD, REQ).
- `init_done` rises the cycle after the final `sccb_done` with `sccb_nack`=0.
- Reset mid-operation: all state returns to reset values on the next clk, even during an outstanding SCCB transaction. Resetting the SCCB master is the caller's responsibility.
- `sccb_ready` high in the same cycle `sccb_valid` rises: the handshake completes in that cycle.

## Configuration
- `OV5640_INIT_DELAY_EN`, defined: an entry with reg_addr=16'hFFFF is a delay pseudo-op.
  - No SCCB request is issued.
  - Enters S_DLY and waits reg_val*MS_CNT cycles, then advances idx as for a successful write.
  - reg_val=0 gives a 1-cycle pass-through.
- Undefined: S_DLY is not built; 16'hFFFF is written to the sensor like any other entry.

## Test plan
- CLK_FREQ_HZ=10_000 (MS_CNT=10), REG_NUM=3, `sccb_ready` tied 1, `sccb_done` returned 5 cycles after the handshake with `sccb_nack`=0:
  - `cam_pwdn` falls at cycle 10 and `cam_rst_n` rises at cycle 20.
  - First `sccb_valid` at cycle 222.
  - Three writes match ROM contents.
  - `init_done`=1 after the third done.
- Same setup, `sccb_ready` held low 7 cycles: `sccb_valid`, `sccb_addr` and `sccb_data` stay stable for all 7 cycles; exactly one request is accepted.
- Entry 1 NACKed twice, then ACKed: the same addr/data is requested 3 times, `init_err`=0, `init_done`=1.
- Entry 0 NACKed 4 times with MAX_RETRY=3: `init_err`=1 after the 4th NACK, no further `sccb_valid`, `init_done` stays 0.
- `rst_n` low for 1 cycle while in S_WAIT of entry 1: outputs return to reset values; the sequence restarts from S_PWDN and entry 0.
- With `OV5640_INIT_DELAY_EN` defined, entry 1 = 24'hFFFF02: no request is issued for entry 1; the gap between entry 0's done and entry 2's `sccb_valid` is 20 + 4 cycles.
